// File: rtl/s_axis_frame_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : s_axis_frame_checker_if
//  Description : AXI-Stream bundle used between a stream source and the
//                frame checker sink.
//                  tdata  - stream data, DATA_WIDTH bits (master -> slave)
//                  tvalid - beat valid                  (master -> slave)
//                  tlast  - end-of-frame marker         (master -> slave)
//                  tready - sink ready                  (slave  -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface s_axis_frame_checker_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/s_axis_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : s_axis_frame_checker
//  Description : AXI-Stream sink that receives fixed-length frames, checks
//                that tlast lands on beat NUM_BEATS-1 and that each beat's
//                tdata equals its index within the frame, and keeps
//                saturating statistics for software readout.
//
//  Ports
//    axi_clk        in   stream clock, rising edge
//    axi_rst        in   asynchronous active-high reset
//    enable         in   accept traffic when 1 (tready follows one cycle later)
//    clear          in   synchronous clear of counters and err_sticky
//    s_axis         if   AXI-Stream slave (tdata/tvalid/tlast in, tready out)
//    beat_idx       out  index of the next expected beat in the current frame
//    frame_count    out  good frames received
//    short_count    out  frames whose tlast came before beat NUM_BEATS-1
//    long_count     out  frames without tlast on beat NUM_BEATS-1
//    data_err_count out  checked beats whose data did not match the index
//    frame_done     out  one-cycle pulse per good frame
//    err_sticky     out  set by any error, cleared by clear
//
//  Revision    : 1.0 - initial release
// ============================================================================
module s_axis_frame_checker #(
    parameter int NUM_BEATS  = 512,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  axi_clk,
    input  wire logic                  axi_rst,
    input  wire logic                  enable,
    input  wire logic                  clear,
    s_axis_frame_checker_if.slave      s_axis,
    output logic [31:0]                beat_idx,
    output logic [31:0]                frame_count,
    output logic [31:0]                short_count,
    output logic [31:0]                long_count,
    output logic [31:0]                data_err_count,
    output logic                       frame_done,
    output logic                       err_sticky
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [31:0] C_LAST_IDX = 32'(NUM_BEATS - 1);
    localparam logic [31:0] C_CNT_MAX  = 32'hFFFF_FFFF;

    // RUN  : every accepted beat is checked against the beat index.
    // DROP : the overlong frame's tail is swallowed until its tlast.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    // Statistics counters stick at all-ones rather than wrapping, so software
    // can tell "a lot" apart from "a few".
    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == C_CNT_MAX) ? v : (v + 32'd1);
    endfunction

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_tready;
    logic        w_tready_nxt;
    logic [31:0] r_beat_idx;
    logic [31:0] w_beat_idx_nxt;
    logic [31:0] r_frame_count;
    logic [31:0] w_frame_count_nxt;
    logic [31:0] r_short_count;
    logic [31:0] w_short_count_nxt;
    logic [31:0] r_long_count;
    logic [31:0] w_long_count_nxt;
    logic [31:0] r_data_err_count;
    logic [31:0] w_data_err_count_nxt;
    logic        r_frame_done;
    logic        w_frame_done_nxt;
    logic        r_err_sticky;
    logic        w_err_sticky_nxt;

    logic                  w_accept;
    logic                  w_at_last;
    logic                  w_data_bad;
    logic [DATA_WIDTH-1:0] w_expected;

    // ------------------------------------------------------------------------
    // Expected payload: the beat index, truncated to a narrow bus or
    // zero-extended onto a wide one.
    // ------------------------------------------------------------------------
    generate
        if (DATA_WIDTH <= 32) begin : g_exp_trunc
            assign w_expected = r_beat_idx[DATA_WIDTH-1:0];
        end else begin : g_exp_zext
            assign w_expected = {{(DATA_WIDTH-32){1'b0}}, r_beat_idx};
        end
    endgenerate

    // tready is registered, so the handshake depends only on flops and tvalid.
    assign w_accept   = s_axis.tvalid && r_tready;
    assign w_at_last  = (r_beat_idx == C_LAST_IDX);
    assign w_data_bad = (s_axis.tdata != w_expected);

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt          = r_state;
        w_tready_nxt         = enable;
        w_beat_idx_nxt       = r_beat_idx;
        w_frame_count_nxt    = r_frame_count;
        w_short_count_nxt    = r_short_count;
        w_long_count_nxt     = r_long_count;
        w_data_err_count_nxt = r_data_err_count;
        w_frame_done_nxt     = 1'b0;
        w_err_sticky_nxt     = r_err_sticky;

        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    // A data error on the final beat is counted but does not
                    // demote the frame: framing and payload are independent.
                    if (w_data_bad) begin
                        w_data_err_count_nxt = f_sat_inc(r_data_err_count);
                        w_err_sticky_nxt     = 1'b1;
                    end

                    if (s_axis.tlast) begin
                        w_beat_idx_nxt = 32'd0;
                        if (w_at_last) begin
                            w_frame_count_nxt = f_sat_inc(r_frame_count);
                            w_frame_done_nxt  = 1'b1;
                        end else begin
                            w_short_count_nxt = f_sat_inc(r_short_count);
                            w_err_sticky_nxt  = 1'b1;
                        end
                    end else if (w_at_last) begin
                        // Frame has run past its length; the rest of it up to
                        // tlast is discarded without checking.
                        w_long_count_nxt = f_sat_inc(r_long_count);
                        w_err_sticky_nxt = 1'b1;
                        w_beat_idx_nxt   = 32'd0;
                        w_state_nxt      = ST_DROP;
                    end else begin
                        w_beat_idx_nxt = r_beat_idx + 32'd1;
                    end
                end
            end

            ST_DROP: begin
                // beat_idx already sits at 0, ready for the following frame.
                if (w_accept && s_axis.tlast) begin
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // clear wins over any same-cycle increment; frame position, state and
        // ready are deliberately left alone so traffic is not disturbed.
        if (clear) begin
            w_frame_count_nxt    = 32'd0;
            w_short_count_nxt    = 32'd0;
            w_long_count_nxt     = 32'd0;
            w_data_err_count_nxt = 32'd0;
            w_err_sticky_nxt     = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state          <= ST_RUN;
            r_tready         <= 1'b0;
            r_beat_idx       <= 32'd0;
            r_frame_count    <= 32'd0;
            r_short_count    <= 32'd0;
            r_long_count     <= 32'd0;
            r_data_err_count <= 32'd0;
            r_frame_done     <= 1'b0;
            r_err_sticky     <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_tready         <= w_tready_nxt;
            r_beat_idx       <= w_beat_idx_nxt;
            r_frame_count    <= w_frame_count_nxt;
            r_short_count    <= w_short_count_nxt;
            r_long_count     <= w_long_count_nxt;
            r_data_err_count <= w_data_err_count_nxt;
            r_frame_done     <= w_frame_done_nxt;
            r_err_sticky     <= w_err_sticky_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axis.tready  = r_tready;
    assign beat_idx       = r_beat_idx;
    assign frame_count    = r_frame_count;
    assign short_count    = r_short_count;
    assign long_count     = r_long_count;
    assign data_err_count = r_data_err_count;
    assign frame_done     = r_frame_done;
    assign err_sticky     = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_s_axis_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s_axis_frame_checker
//  Description : Self-checking bench for s_axis_frame_checker. Frames are
//                built as arrays of beats; expected statistics are derived
//                per frame from its length and contents.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_s_axis_frame_checker;

    localparam int NUM_BEATS  = 512;
    localparam int DATA_WIDTH = 32;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic        enable;
    logic        clear;
    logic [31:0] beat_idx;
    logic [31:0] frame_count;
    logic [31:0] short_count;
    logic [31:0] long_count;
    logic [31:0] data_err_count;
    logic        frame_done;
    logic        err_sticky;

    s_axis_frame_checker_if #(.DATA_WIDTH(DATA_WIDTH)) s_axis ();

    s_axis_frame_checker #(
        .NUM_BEATS  (NUM_BEATS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dut (
        .axi_clk        (axi_clk),
        .axi_rst        (axi_rst),
        .enable         (enable),
        .clear          (clear),
        .s_axis         (s_axis),
        .beat_idx       (beat_idx),
        .frame_count    (frame_count),
        .short_count    (short_count),
        .long_count     (long_count),
        .data_err_count (data_err_count),
        .frame_done     (frame_done),
        .err_sticky     (err_sticky)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulse_base = 0;
    int cyc = 0;

    // Reference statistics
    int exp_frames, exp_short, exp_long, exp_derr, exp_pulses;
    bit exp_sticky;

    logic [31:0] fdata[$];

    always @(negedge axi_clk) begin
        if (frame_done === 1'b1) pulses++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        exp_frames = 0; exp_short = 0; exp_long = 0; exp_derr = 0;
        exp_sticky = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        repeat (n) begin
            @(posedge axi_clk); #1;
            cyc++;
        end
    endtask

    // Present one beat until it is accepted. In throttle mode enable toggles
    // every 3 cycles and tvalid is a coin flip; tready must lag enable by one.
    task automatic send_beat(input logic [31:0] d, input bit last,
                             input bit throttle, input bit clr);
        bit hs;
        bit en_prev;
        bit done = 1'b0;
        int n = 0;
        while (!done) begin
            if (throttle) begin
                enable        = ((cyc / 3) % 2) == 0;
                s_axis.tvalid = ($urandom_range(0, 1) == 1);
            end else begin
                s_axis.tvalid = 1'b1;
            end
            s_axis.tdata = s_axis.tvalid ? d : $urandom();
            s_axis.tlast = s_axis.tvalid ? last : 1'($urandom_range(0, 1));
            clear        = clr;
            hs      = s_axis.tvalid && s_axis.tready;
            en_prev = enable;
            @(posedge axi_clk); #1;
            cyc++;
            clear = 1'b0;
            if (throttle) check("tready_lag", 32'(s_axis.tready), 32'(en_prev));
            done = hs;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $error("FAIL hs_timeout observed=no_handshake expected=handshake");
                done = 1'b1;
            end
        end
    endtask

    task automatic build_nominal(input int len);
        fdata.delete();
        for (int i = 0; i < len; i++) fdata.push_back(32'(i));
    endtask

    // Send fdata as one frame and fold its effect into the reference stats.
    task automatic send_frame(input bit throttle, input bit clr_on_last);
        int len;
        int chk;
        int derr;
        len = fdata.size();
        for (int i = 0; i < len; i++)
            send_beat(fdata[i], i == len - 1, throttle, clr_on_last && (i == len - 1));
        // Only beats up to the expected frame length are payload-checked.
        chk  = (len < NUM_BEATS) ? len : NUM_BEATS;
        derr = 0;
        for (int i = 0; i < chk; i++)
            if (fdata[i] != 32'(i)) derr++;
        if (len == NUM_BEATS) exp_pulses++;
        if (clr_on_last) begin
            model_zero();
        end else begin
            exp_derr += derr;
            if (derr != 0) exp_sticky = 1'b1;
            if (len == NUM_BEATS)     exp_frames++;
            else if (len < NUM_BEATS) begin exp_short++; exp_sticky = 1'b1; end
            else                      begin exp_long++;  exp_sticky = 1'b1; end
        end
        if (throttle) enable = 1'b1;
        idle(3);
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".frames"},   frame_count,    32'(exp_frames));
        check({tag, ".short"},    short_count,    32'(exp_short));
        check({tag, ".long"},     long_count,     32'(exp_long));
        check({tag, ".derr"},     data_err_count, 32'(exp_derr));
        check({tag, ".sticky"},   32'(err_sticky), 32'(exp_sticky));
        check({tag, ".beat_idx"}, beat_idx,       32'd0);
        check({tag, ".pulses"},   32'(pulses - pulse_base), 32'(exp_pulses));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge axi_clk); #1;
        cyc++;
        clear = 1'b0;
        model_zero();
    endtask

    initial begin
        axi_rst       = 1'b1;
        enable        = 1'b0;
        clear         = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        model_zero();
        exp_pulses = 0;
        repeat (3) @(posedge axi_clk);
        #1;
        check("rst.tready", 32'(s_axis.tready), 32'd0);
        check_stats("rst");

        axi_rst = 1'b0;
        enable  = 1'b1;
        idle(2);
        check("en.tready", 32'(s_axis.tready), 32'd1);

        // 1. nominal back-to-back frames
        for (int f = 0; f < 3; f++) begin
            build_nominal(NUM_BEATS);
            for (int i = 0; i < NUM_BEATS; i++)
                send_beat(fdata[i], i == NUM_BEATS - 1, 1'b0, 1'b0);
            exp_frames++;
            exp_pulses++;
        end
        idle(3);
        check_stats("nominal");

        // 2. short frame then nominal
        do_clear();
        build_nominal(100);
        send_frame(1'b0, 1'b0);
        check_stats("short");
        build_nominal(NUM_BEATS);
        send_frame(1'b0, 1'b0);
        check_stats("after_short");

        // 3. long frame then nominal
        do_clear();
        build_nominal(600);
        send_frame(1'b0, 1'b0);
        check_stats("long");
        build_nominal(NUM_BEATS);
        send_frame(1'b0, 1'b0);
        check_stats("after_long");

        // 4. data corruption
        do_clear();
        build_nominal(NUM_BEATS);
        fdata[7]   = 32'hDEAD_BEEF;
        fdata[300] = 32'd0;
        send_frame(1'b0, 1'b0);
        check_stats("corrupt");

        // 5. backpressure and throttling
        do_clear();
        build_nominal(NUM_BEATS);
        send_frame(1'b1, 1'b0);
        check_stats("throttle");

        // Random frames: short, nominal or long, with sparse corruption
        do_clear();
        for (int f = 0; f < 4; f++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 2));
            len  = (kind == 0) ? int'($urandom_range(2, NUM_BEATS - 1)) :
                   (kind == 1) ? NUM_BEATS :
                                 NUM_BEATS + int'($urandom_range(1, 40));
            build_nominal(len);
            for (int i = 0; i < len; i++)
                if ($urandom_range(0, 63) == 0) fdata[i] = $urandom();
            send_frame(f == 3, 1'b0);
            check_stats("random");
        end

        // 6a. asynchronous reset mid-frame
        do_clear();
        for (int i = 0; i < 250; i++) send_beat(32'(i), 1'b0, 1'b0, 1'b0);
        s_axis.tvalid = 1'b0;
        check("mid.beat_idx", beat_idx, 32'd250);
        #3;
        axi_rst = 1'b1;
        #1;
        check("async.beat_idx", beat_idx, 32'd0);
        check("async.tready", 32'(s_axis.tready), 32'd0);
        @(posedge axi_clk); #1;
        axi_rst = 1'b0;
        model_zero();
        exp_pulses = 0;
        pulse_base = pulses;
        build_nominal(NUM_BEATS);
        send_frame(1'b0, 1'b0);
        check_stats("after_rst");

        // 6b. clear coinciding with a good frame's tlast
        build_nominal(10);
        send_frame(1'b0, 1'b0);
        check("pre_clear.sticky", 32'(err_sticky), 32'd1);
        build_nominal(NUM_BEATS);
        send_frame(1'b0, 1'b1);
        check_stats("clear_last");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s_axis_frame_checker.md
Name: s_axis_frame_checker

Overview:
- AXI-Stream slave (sink) that receives fixed-length packets from a stream master, checks their framing, and checks their payload.
- Framing check: tlast must land on beat NUM_BEATS-1.
- Payload check: tdata must follow the incrementing beat-index pattern.
- Accumulates good-frame and error statistics for software readout.
- Sits at the far end of the stream source, standing in for the DMA sink during bring-up and loopback tests.

Parameters:
- NUM_BEATS, 512, beats per valid frame (>=2).
- DATA_WIDTH, 32, tdata width in bits (8..64).

Ports:
- axi_clk, input, 1, stream clock; all logic is on the rising edge.
- axi_rst, input, 1, asynchronous active-high reset.
- enable, input, 1, accept traffic when 1.
- clear, input, 1, synchronous clear of statistics and sticky flags.
- s_axis_tdata, input, DATA_WIDTH, stream data.
- s_axis_tvalid, input, 1, stream valid.
- s_axis_tlast, input, 1, end-of-frame marker.
- s_axis_tready, output, 1, sink ready (registered).
- beat_idx, output, 32, index of the next expected beat within the current frame.
- frame_count, output, 32, number of good frames received.
- short_count, output, 32, frames that ended early.
- long_count, output, 32, frames that overran NUM_BEATS.
- data_err_count, output, 32, beats with mismatched data.
- frame_done, output, 1, one-cycle pulse on each good frame.
- err_sticky, output, 1, set by any error; cleared by clear.

Behaviour:
- Reset: asserting axi_rst asynchronously sets every output to 0 and the state to RUN.
- Ready:
  - s_axis_tready <= enable each cycle, so ready follows enable with 1 cycle of latency.
  - A beat is accepted only on a cycle where s_axis_tvalid && s_axis_tready.
  - Dropping enable mid-frame stalls the frame; it does not abort it. beat_idx and state hold until traffic resumes.
- States:
  - RUN: checking.
  - DROP: discarding the tail of an overlong frame.
- RUN, per accepted beat:
  - Data check: expected value is beat_idx[DATA_WIDTH-1:0], zero-extended. On mismatch: data_err_count+1 and err_sticky<=1.
  - tlast=1 and beat_idx==NUM_BEATS-1: good frame. frame_count+1, frame_done=1 on the next cycle, beat_idx<=0.
  - tlast=1 and beat_idx<NUM_BEATS-1: short frame. short_count+1, err_sticky<=1, beat_idx<=0, stay in RUN.
  - tlast=0 and beat_idx==NUM_BEATS-1: long frame. long_count+1, err_sticky<=1, beat_idx<=0, go to DROP.
  - Otherwise: beat_idx+1.
  - A beat at NUM_BEATS-1 that has both a data error and tlast=1 counts the data error and still counts as a good frame.
- DROP:
  - Accept beats with no data check and no change to beat_idx.
  - The beat carrying tlast=1 is the last beat discarded; after it, return to RUN with beat_idx=0.
  - The beat after that tlast is checked as beat 0 of a new frame.
- Counters:
  - 32-bit and saturating at 0xFFFFFFFF; they never wrap.
  - frame_done is a pulse only: high for exactly 1 cycle per good frame. Back-to-back good frames give pulses on consecutive frame ends.
- clear:
  - Zeros frame_count, short_count, long_count, data_err_count and err_sticky.
  - Overrides any increment in the same cycle, so the result is 0.
  - Does not touch beat_idx, state or s_axis_tready.
- Reset mid-frame: the partial frame is forgotten and no count is updated; the next accepted beat is beat 0.
- No combinational path exists from any input to s_axis_tready.

Test Plan:
1. Nominal frames:
   - Stimulus: enable=1, three back-to-back frames of 512 beats, tdata=0..511, tlast on beat 511, tvalid held high.
   - Response: frame_count=3, three frame_done pulses, all error counts 0, err_sticky=0.
2. Short frame:
   - Stimulus: tlast on beat 99, then one nominal frame.
   - Response: short_count=1, frame_count=1, err_sticky=1, and the second frame is checked from beat 0.
3. Long frame:
   - Stimulus: a 600-beat frame with tlast on beat 599, then one nominal frame.
   - Response: long_count=1, data_err_count=0 (beats 512..599 are dropped), frame_count=1.
4. Data corruption:
   - Stimulus: a nominal frame with tdata on beat 7 set to 0xDEADBEEF and on beat 300 set to 0.
   - Response: data_err_count=2, frame_count=1, err_sticky=1.
5. Backpressure and throttling:
   - Stimulus: toggle enable every 3 cycles and assert tvalid randomly with 50% density over a nominal frame.
   - Response: s_axis_tready lags enable by 1 cycle, frame_count=1, no errors, and the data on stalled cycles is never counted.
6. Reset and clear:
   - Stimulus: assert axi_rst at beat 250, then send one nominal frame. Separately, pulse clear on the same cycle as a good frame's tlast beat.
   - Response: after the reset, frame_count=1 and short_count=0. After the clear, frame_count reads 0 and err_sticky=0.
